square_gen_seq: RTL and testbench

- Parametrised sequential squarer that generalises the 2-bit N-to-N^2 generator to a WIDTH-bit operand.
- Computes D = N*N with a shift-add datapath, one operand bit per clock.
- Uses valid/ready handshakes on input and output, so it can sit between streaming producer and consumer stages in the arithmetic test designs.

---
 rtl/square_gen_seq.sv | 117 +++++++++++
 tb/tb_square_gen_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_gen_seq.sv
// -----------------------------------------------------------------------------
// square_gen_seq
//   Sequential shift-add squarer. It accepts a WIDTH-bit unsigned operand N over
//   a valid/ready handshake and returns D = N*N (2*WIDTH bits) over a second
//   valid/ready handshake. One multiplier bit is processed per clock, so the
//   result appears exactly WIDTH edges after the accept edge.
//
//   Optional build macro: SQUARE_GEN_ACC_EN adds a running sum of squares.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand present on in_n
//   in_n       in   [WIDTH-1:0]   unsigned operand
//   in_ready   out  block can accept an operand (IDLE)
//   out_valid  out  out_d holds a valid result (DONE)
//   out_d      out  [2*WIDTH-1:0] result N^2
//   out_ready  in   consumer accepts the result
//   busy       out  high while computing (CALC)
//   acc_clr    in   (SQUARE_GEN_ACC_EN) clear the sum of squares
//   acc_sum    out  (SQUARE_GEN_ACC_EN) [2*WIDTH+7:0] wrapping sum of squares
// -----------------------------------------------------------------------------
module square_gen_seq #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_n,
   output logic               in_ready,
   output logic               out_valid,
   output logic [2*WIDTH-1:0] out_d,
   input  logic               out_ready,
   output logic               busy
`ifdef SQUARE_GEN_ACC_EN
   ,
   input  logic               acc_clr,
   output logic [2*WIDTH+7:0] acc_sum
`endif
);

   localparam int DW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [DW-1:0]    acc;
   logic [DW-1:0]    acc_nxt;
   logic [CW-1:0]    cnt;
   logic             last;

   // last CALC edge is the one that processes bit WIDTH-1
   assign last    = (cnt == CW'(WIDTH - 1));
   assign acc_nxt = acc + (mplier[0] ? (DW'(mcand) << cnt) : '0);

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == CALC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = CALC;
         CALC:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath; in_n is only looked at on the accept edge, so X on an idle
   // bus never reaches a register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
         out_d  <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               mcand  <= in_n;
               mplier <= in_n;
               acc    <= '0;
               cnt    <= '0;
            end
            CALC: begin
               acc    <= acc_nxt;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
               if (last) out_d <= acc_nxt;
            end
            default: ;
         endcase
      end
   end

`ifdef SQUARE_GEN_ACC_EN
   localparam int SW = DW + 8;

   // clear has priority over a same-edge add
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      acc_sum <= '0;
      else if (acc_clr)                acc_sum <= '0;
      else if (out_valid && out_ready) acc_sum <= acc_sum + SW'(out_d);
   end
`endif

endmodule

// File: tb/tb_square_gen_seq.sv
module tb_square_gen_seq;

   logic       clk;
   // WIDTH=4 instance
   logic       rst_n, in_valid, in_ready, out_valid, out_ready, busy;
   logic [3:0] in_n;
   logic [7:0] out_d;
   // WIDTH=8 instance
   logic        rst8_n, iv8, ir8, ov8, ordy8, busy8;
   logic [7:0]  in8;
   logic [15:0] od8;
`ifdef SQUARE_GEN_ACC_EN
   logic        acc_clr;
   logic [15:0] acc_sum;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   square_gen_seq #(.WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_n(in_n),
      .in_ready(in_ready), .out_valid(out_valid), .out_d(out_d),
      .out_ready(out_ready), .busy(busy)
`ifdef SQUARE_GEN_ACC_EN
      , .acc_clr(acc_clr), .acc_sum(acc_sum)
`endif
   );

   square_gen_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_n(in8),
      .in_ready(ir8), .out_valid(ov8), .out_d(od8),
      .out_ready(ordy8), .busy(busy8)
`ifdef SQUARE_GEN_ACC_EN
      , .acc_clr(1'b0), .acc_sum()
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // waits (bounded) for out_valid of the WIDTH=4 instance; lat = edges waited
   task automatic wait_out(output int lat, output bit ok);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      ok = out_valid;
   endtask

   task automatic wait_in_ready(output bit ok);
      int n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      ok = in_ready;
   endtask

   task automatic test_reset();
      rst_n = 0; rst8_n = 0;
      in_valid = 0; in_n = 0; out_ready = 0;
      iv8 = 0; in8 = 0; ordy8 = 0;
`ifdef SQUARE_GEN_ACC_EN
      acc_clr = 0;
`endif
      repeat (2) tick();
      rst_n = 1; rst8_n = 1;
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_d !== 8'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: ir=%b ov=%b d=%0d busy=%b, required ir=1 ov=0 d=0 busy=0",
                  in_ready, out_valid, out_d, busy);
      end
`ifdef SQUARE_GEN_ACC_EN
      n_checks++;
      if (acc_sum !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_acc_sum: got %0d required 0", acc_sum);
      end
`endif
   endtask

   task automatic test_single();
      int lat; bit ok;
      in_n = 4'd3; in_valid = 1; out_ready = 1;
      tick();                         // accept edge
      in_valid = 0;
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL single_busy: busy=%b ir=%b required busy=1 ir=0", busy, in_ready);
      end
      wait_out(lat, ok);
      n_checks++;
      if (!ok || lat != 4 || out_d !== 8'd9) begin
         n_fail++;
         $display("FAIL single_result: ok=%b lat=%0d d=%0d required lat=4 d=9", ok, lat, out_d);
      end
      tick();                         // handshake edge
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_return: ir=%b ov=%b required ir=1 ov=0", in_ready, out_valid);
      end
   endtask

   task automatic test_sweep();
      int lat; bit ok;
      out_ready = 1; in_valid = 1; in_n = 4'd0;
      for (int i = 0; i < 16; i++) begin
         wait_in_ready(ok);
         if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL sweep_ready_timeout: op %0d in_ready=%b required 1", i, in_ready);
            break;
         end
         tick();                      // accept i
         in_n = 4'(i + 1);            // next operand presented, held until ready
         wait_out(lat, ok);
         n_checks++;
         if (!ok || lat != 4 || out_d !== 8'(i * i)) begin
            n_fail++;
            $display("FAIL sweep_result: op %0d ok=%b lat=%0d d=%0d required lat=4 d=%0d",
                     i, ok, lat, out_d, i * i);
         end
         tick();                      // handshake
      end
      in_valid = 0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL sweep_idle_after: busy=%b ir=%b required busy=0 ir=1", busy, in_ready);
      end
   endtask

   task automatic test_backpressure();
      int lat; bit ok;
      out_ready = 0; in_n = 4'd15; in_valid = 1;
      tick();
      in_valid = 0;
      in_n = 'x;                      // idle bus may float
      wait_out(lat, ok);
      n_checks++;
      if (!ok || out_d !== 8'd225) begin
         n_fail++;
         $display("FAIL bp_result: ok=%b d=%0d required 225", ok, out_d);
      end
      for (int c = 0; c < 10; c++) begin
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_d !== 8'd225 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: cyc %0d ov=%b d=%0d ir=%b required ov=1 d=225 ir=0",
                     c, out_valid, out_d, in_ready);
         end
      end
      out_ready = 1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: ov=%b ir=%b required ov=0 ir=1", out_valid, in_ready);
      end
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || ^out_d === 1'bx) begin
         n_fail++;
         $display("FAIL bp_single_hs_xclean: ov=%b busy=%b d=%h required ov=0 busy=0 d known",
                  out_valid, busy, out_d);
      end
      in_n = 4'd0;
   endtask

   task automatic test_ignore_in_calc();
      int lat; bit ok;
      out_ready = 0; in_n = 4'd5; in_valid = 1;
      tick();
      in_n = 4'd7;                    // held valid during CALC
      wait_out(lat, ok);
      n_checks++;
      if (!ok || lat != 4 || out_d !== 8'd25) begin
         n_fail++;
         $display("FAIL calc_first: ok=%b lat=%0d d=%0d required lat=4 d=25", ok, lat, out_d);
      end
      out_ready = 1;
      tick();                         // handshake, back to IDLE
      tick();                         // accepts 7
      in_valid = 0;
      wait_out(lat, ok);
      n_checks++;
      if (!ok || lat != 4 || out_d !== 8'd49) begin
         n_fail++;
         $display("FAIL calc_second: ok=%b lat=%0d d=%0d required lat=4 d=49", ok, lat, out_d);
      end
      tick();
   endtask

   task automatic test_async_reset_w8();
      int lat;
      in8 = 8'd200; iv8 = 1; ordy8 = 1;
      tick();                         // accept
      iv8 = 0;
      repeat (3) tick();              // 3 CALC edges
      n_checks++;
      if (busy8 !== 1'b1) begin
         n_fail++;
         $display("FAIL w8_busy_before_rst: busy=%b required 1", busy8);
      end
      #2 rst8_n = 0;                  // mid-cycle, away from any edge
      #1;
      n_checks++;
      if (ov8 !== 1'b0 || busy8 !== 1'b0) begin
         n_fail++;
         $display("FAIL w8_async_rst: ov=%b busy=%b required ov=0 busy=0", ov8, busy8);
      end
      tick();
      rst8_n = 1;
      tick();
      n_checks++;
      if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
         n_fail++;
         $display("FAIL w8_after_release: ir=%b ov=%b required ir=1 ov=0", ir8, ov8);
      end
      in8 = 8'd255; iv8 = 1;
      tick();
      iv8 = 0;
      lat = 0;
      while (!ov8 && lat < 40) begin
         tick();
         lat++;
      end
      n_checks++;
      if (ov8 !== 1'b1 || lat != 8 || od8 !== 16'd65025) begin
         n_fail++;
         $display("FAIL w8_max: ov=%b lat=%0d d=%0d required lat=8 d=65025", ov8, lat, od8);
      end
      tick();
   endtask

`ifdef SQUARE_GEN_ACC_EN
   task automatic test_acc();
      int lat; bit ok;
      acc_clr = 1;
      tick();
      acc_clr = 0;
      out_ready = 1;
      for (int i = 1; i <= 3; i++) begin
         in_n = 4'(i); in_valid = 1;
         tick();
         in_valid = 0;
         wait_out(lat, ok);
         tick();
      end
      n_checks++;
      if (acc_sum !== 16'd14) begin
         n_fail++;
         $display("FAIL acc_sum_123: got %0d required 14", acc_sum);
      end
      in_n = 4'd4; in_valid = 1;
      tick();
      in_valid = 0;
      wait_out(lat, ok);
      acc_clr = 1;                    // same edge as handshake of 16
      tick();
      acc_clr = 0;
      n_checks++;
      if (acc_sum !== 16'd0) begin
         n_fail++;
         $display("FAIL acc_clr_wins: got %0d required 0", acc_sum);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_sweep();
      test_backpressure();
      test_ignore_in_calc();
      test_async_reset_w8();
`ifdef SQUARE_GEN_ACC_EN
      test_acc();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
